// File: rtl/tipi_pkg.sv
// tipi_pkg: shared types and address helpers for the TIPI mailbox.
// Holds the serial FSM state enum, the TI address map helpers, the STATUS
// byte bit positions and the default synchroniser depth.
package tipi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TX   = 2'd1,
      RX   = 2'd2
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;

   // STATUS byte layout: td_pend in the low bits, rd_pend from bit 4, sticky error at bit 7
   localparam int ST_TD_LSB  = 0;
   localparam int ST_RD_LSB  = 4;
   localparam int ST_ERR_BIT = 7;

   // TI write address of TI-to-RPi mailbox k
   function automatic logic [15:0] td_addr(input logic [15:0] top, input int k);
      return top - 16'(2 * k);
   endfunction

   // TI read address of RPi-to-TI mailbox k (placed below all td registers)
   function automatic logic [15:0] rd_addr(input logic [15:0] top, input int n_chan, input int k);
      return top - 16'(2 * n_chan) - 16'(2 * k);
   endfunction

   // TI read address of the STATUS byte (below all rd registers)
   function automatic logic [15:0] status_addr(input logic [15:0] top, input int n_chan);
      return top - 16'(4 * n_chan);
   endfunction

endpackage

// File: rtl/tipi_sync_edge.sv
// tipi_sync_edge: STAGES-deep synchroniser for one asynchronous level with
// single-cycle rise and fall pulses in the clk domain.
module tipi_sync_edge
   import tipi_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // shift the async level through the chain and keep the last synced value for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         prev  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;
   assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/tipi_mailbox.sv
// tipi_mailbox: clocked TI <-> RPi byte mailboxes with pending flags,
// TI-readable STATUS, bit-count frame checking and an optional interrupt.
// Optional feature macro: TIPI_EXTINT_EN (drives ti_extint_n from rd_pend).
//
// Handshakes: a TI write is taken on the synced rising edge of its qualified
// strobe, a TI read side effect (pend/err clear) on the synced falling edge of
// the read strobe; RPi r_clk/r_le act on their synced rising edges, with
// r_rt, r_sel and r_dout sampled in that same cycle.
module tipi_mailbox
   import tipi_pkg::*;
#(
   parameter int          N_CHAN      = 2,
   parameter logic [15:0] TOP_ADDR    = 16'h5FFF,
   parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int         SEL_W       = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dsr_en,
   input  logic [15:0]       ti_a,
   input  logic              ti_memen,
   input  logic              ti_we,
   input  logic              ti_dbin,
   input  logic [7:0]        ti_d_in,
   output logic [7:0]        ti_d_out,
   output logic              ti_d_oe,
   input  logic              r_clk,
   input  logic              r_le,
   input  logic              r_rt,
   input  logic [SEL_W-1:0]  r_sel,
   input  logic              r_dout,
   output logic              r_din,
   output logic [N_CHAN-1:0] td_pend,
   output logic [N_CHAN-1:0] rd_pend,
   output logic              ti_extint_n,
   output logic [1:0]        state_dbg
);

   logic [7:0]        td [N_CHAN];
   logic [7:0]        rd [N_CHAN];
   logic              err;
   logic [7:0]        sr;
   logic [3:0]        cnt;
   state_t            state, state_nx;

   logic [N_CHAN-1:0] td_hit, rd_hit;
   logic              st_hit;
   logic              wq, rq;
   logic [N_CHAN-1:0] wq_hit_q, rq_hit_q;
   logic [7:0]        wq_data_q;
   logic              rq_st_q;
   logic [7:0]        status, rd_mux, td_sel;
   logic [N_CHAN-1:0] sel_hot;
   logic              sel_ok;

   logic rclk_rise, rle_rise, wq_rise, rq_fall;
   logic rclk_fall_unused, rle_fall_unused, wq_fall_unused, rq_rise_unused;

   // TI address decode for every mailbox and the STATUS byte
   always_comb begin
      td_hit = '0;
      rd_hit = '0;
      for (int k = 0; k < N_CHAN; k++) begin
         td_hit[k] = (ti_a == td_addr(TOP_ADDR, k));
         rd_hit[k] = (ti_a == rd_addr(TOP_ADDR, N_CHAN, k));
      end
      st_hit = (ti_a == status_addr(TOP_ADDR, N_CHAN));
   end

   assign wq = dsr_en & ~ti_memen & ~ti_we  & (|td_hit);
   assign rq = dsr_en & ~ti_memen &  ti_dbin & ((|rd_hit) | st_hit);

   tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rclk (
      .clk(clk), .reset_n(reset_n), .async_in(r_clk), .rise(rclk_rise), .fall(rclk_fall_unused));
   tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rle (
      .clk(clk), .reset_n(reset_n), .async_in(r_le), .rise(rle_rise), .fall(rle_fall_unused));
   tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wq (
      .clk(clk), .reset_n(reset_n), .async_in(wq), .rise(wq_rise), .fall(wq_fall_unused));
   tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rq (
      .clk(clk), .reset_n(reset_n), .async_in(rq), .rise(rq_rise_unused), .fall(rq_fall));

   // remember the target and data of an access while its strobe is asserted,
   // so the late synced edge still knows what the TI addressed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wq_hit_q  <= '0;
         wq_data_q <= '0;
         rq_hit_q  <= '0;
         rq_st_q   <= 1'b0;
      end else begin
         if (wq) begin
            wq_hit_q  <= td_hit;
            wq_data_q <= ti_d_in;
         end
         if (rq) begin
            rq_hit_q <= rd_hit;
            rq_st_q  <= st_hit;
         end
      end
   end

   // STATUS byte and TI read data mux; the bus is driven only during rq
   always_comb begin
      status = '0;
      status[ST_TD_LSB +: N_CHAN] = td_pend;
      status[ST_RD_LSB +: N_CHAN] = rd_pend;
      status[ST_ERR_BIT]          = err;
      rd_mux = '0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (rd_hit[k]) rd_mux = rd[k];
      end
      if (st_hit) rd_mux = status;
   end

   assign ti_d_oe  = rq;
   assign ti_d_out = rq ? rd_mux : 8'h00;

   // channel select: out-of-range selects hit no mailbox and load 0
   if (N_CHAN == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_part
      assign sel_ok = (r_sel < SEL_W'(N_CHAN));
   end

   // one-hot channel select and the td byte it addresses
   always_comb begin
      sel_hot = '0;
      td_sel  = '0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (sel_ok && (r_sel == SEL_W'(k))) begin
            sel_hot[k] = 1'b1;
            td_sel     = td[k];
         end
      end
   end

   // serial FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // serial FSM next-state: r_le starts/ends frames, r_clk shifts bits
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (rle_rise && r_rt)        state_nx = TX;
            else if (rclk_rise && !r_rt) state_nx = RX;
         end
         TX: begin
            if (rle_rise)                       state_nx = TX;
            else if (rclk_rise && cnt == 4'd7)  state_nx = IDLE;
         end
         RX: begin
            if (rle_rise) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // serial FSM outputs: MSB of sr goes to the RPi only while transmitting
   always_comb begin
      r_din     = (state == TX) ? sr[7] : 1'b0;
      state_dbg = state;
   end

   // mailbox datapath; statement order sets priority (write wins over load,
   // commit wins over the TI read clear)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_CHAN; k++) begin
            td[k] <= '0;
            rd[k] <= '0;
         end
         td_pend <= '0;
         rd_pend <= '0;
         err     <= 1'b0;
         sr      <= '0;
         cnt     <= '0;
      end else begin
         if (rq_fall) begin
            for (int k = 0; k < N_CHAN; k++) begin
               if (rq_hit_q[k]) rd_pend[k] <= 1'b0;
            end
            if (rq_st_q) err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rle_rise && r_rt) begin
                  sr      <= td_sel;
                  cnt     <= 4'd0;
                  td_pend <= td_pend & ~sel_hot;
               end else if (rclk_rise && !r_rt) begin
                  sr  <= {sr[6:0], r_dout};
                  cnt <= 4'd1;
               end
            end
            TX: begin
               if (rle_rise) begin
                  sr      <= td_sel;
                  cnt     <= 4'd0;
                  td_pend <= td_pend & ~sel_hot;
               end else if (rclk_rise) begin
                  sr  <= {sr[6:0], 1'b0};
                  cnt <= cnt + 4'd1;
               end
            end
            RX: begin
               if (rle_rise) begin
                  if (cnt == 4'd8) begin
                     for (int k = 0; k < N_CHAN; k++) begin
                        if (sel_hot[k]) begin
                           rd[k]      <= sr;
                           rd_pend[k] <= 1'b1;
                        end
                     end
                  end else begin
                     err <= 1'b1;
                  end
               end else if (rclk_rise) begin
                  sr <= {sr[6:0], r_dout};
                  if (cnt != 4'd8) cnt <= cnt + 4'd1;
               end
            end
            default: ;
         endcase

         if (wq_rise) begin
            for (int k = 0; k < N_CHAN; k++) begin
               if (wq_hit_q[k]) begin
                  td[k]      <= wq_data_q;
                  td_pend[k] <= 1'b1;
               end
            end
         end
      end
   end

`ifdef TIPI_EXTINT_EN
   // interrupt asserted while the TI has unread RPi bytes and the block is enabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ti_extint_n <= 1'b1;
      else          ti_extint_n <= ~(dsr_en & (|rd_pend));
   end
`else
   assign ti_extint_n = 1'b1;
`endif

endmodule

// File: tb/tb_tipi_mailbox.sv
// tb_tipi_mailbox: directed and randomized checks of tipi_mailbox (N_CHAN=2)
// against a mailbox-level reference model.
module tb_tipi_mailbox;

  localparam int N_CHAN = 2;

  logic        clk = 1'b0;
  logic        reset_n, dsr_en, ti_memen, ti_we, ti_dbin;
  logic [15:0] ti_a;
  logic [7:0]  ti_d_in, ti_d_out;
  logic        ti_d_oe;
  logic        r_clk, r_le, r_rt, r_dout, r_din, ti_extint_n;
  logic [0:0]  r_sel;
  logic [1:0]  td_pend, rd_pend, state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model: the mailbox contents and flags as the TI/RPi see them
  logic [7:0]        td_m [N_CHAN];
  logic [7:0]        rd_m [N_CHAN];
  logic [N_CHAN-1:0] td_pend_m, rd_pend_m;
  logic              err_m;

  logic [15:0] td_adr [N_CHAN] = '{16'h5FFF, 16'h5FFD};
  logic [15:0] rd_adr [N_CHAN] = '{16'h5FFB, 16'h5FF9};
  localparam logic [15:0] ST_ADR = 16'h5FF7;

  tipi_mailbox #(.N_CHAN(N_CHAN), .TOP_ADDR(16'h5FFF), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .dsr_en(dsr_en), .ti_a(ti_a),
    .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
    .ti_d_in(ti_d_in), .ti_d_out(ti_d_out), .ti_d_oe(ti_d_oe),
    .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_sel(r_sel), .r_dout(r_dout),
    .r_din(r_din), .td_pend(td_pend), .rd_pend(rd_pend),
    .ti_extint_n(ti_extint_n), .state_dbg(state_dbg));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] status_m();
    return {err_m, 1'b0, rd_pend_m, 2'b00, td_pend_m};
  endfunction

  function automatic logic ext_m();
`ifdef TIPI_EXTINT_EN
    return ~(dsr_en & (|rd_pend_m));
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CHAN; k++) begin
      td_m[k] = 8'h00;
      rd_m[k] = 8'h00;
    end
    td_pend_m = '0;
    rd_pend_m = '0;
    err_m     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".td_pend"}, td_pend, td_pend_m);
    check({tag, ".rd_pend"}, rd_pend, rd_pend_m);
    check({tag, ".extint"}, ti_extint_n, ext_m());
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ti_write(input int k, input logic [7:0] data);
    ti_a = td_adr[k]; ti_d_in = data; ti_memen = 1'b0; ti_we = 1'b0;
    tick(6);
    ti_we = 1'b1; ti_memen = 1'b1;
    tick(4);
    if (dsr_en) begin
      td_m[k] = data;
      td_pend_m[k] = 1'b1;
    end
  endtask

  // read one byte; data/oe sampled while the strobe is active, oe_after once released
  task automatic ti_read(input logic [15:0] adr, output logic [7:0] data, output logic oe,
                         output logic oe_after);
    ti_a = adr; ti_memen = 1'b0; ti_dbin = 1'b1;
    tick(1);
    data = ti_d_out; oe = ti_d_oe;
    tick(5);
    ti_dbin = 1'b0; ti_memen = 1'b1;
    tick(5);
    oe_after = ti_d_oe;
  endtask

  task automatic rpi_bit(input logic b);
    r_dout = b; r_clk = 1'b1;
    tick(6);
    r_clk = 1'b0;
    tick(6);
  endtask

  task automatic rpi_le();
    r_le = 1'b1;
    tick(6);
    r_le = 1'b0;
    tick(6);
  endtask

  task automatic rpi_send(input int sel, input logic [15:0] v, input int nbits);
    r_rt = 1'b0; r_sel = 1'(sel);
    for (int i = 0; i < nbits; i++) rpi_bit(v[nbits-1-i]);
    rpi_le();
    if (nbits >= 8) begin
      rd_m[sel] = v[7:0];
      rd_pend_m[sel] = 1'b1;
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic rpi_shift_out(output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], r_din};
      rpi_bit(1'b0);
    end
  endtask

  task automatic rpi_recv(input int sel, output logic [7:0] got);
    r_rt = 1'b1; r_sel = 1'(sel);
    rpi_le();
    rpi_shift_out(got);
  endtask

  // ti read with model update and checks
  task automatic ti_read_check(input string tag, input int tgt);
    logic [7:0] d;
    logic oe, oe_after;
    logic [7:0] exp;
    if (tgt == N_CHAN) begin
      exp = status_m();
      ti_read(ST_ADR, d, oe, oe_after);
      if (dsr_en) err_m = 1'b0;
    end else begin
      exp = rd_m[tgt];
      ti_read(rd_adr[tgt], d, oe, oe_after);
      if (dsr_en) rd_pend_m[tgt] = 1'b0;
    end
    if (!dsr_en) exp = 8'h00;
    check({tag, ".data"}, d, exp);
    check({tag, ".oe"}, oe, dsr_en);
    check({tag, ".oe_after"}, oe_after, 1'b0);
  endtask

  task automatic recv_check(input string tag, input int sel);
    logic [7:0] got;
    rpi_recv(sel, got);
    check({tag, ".byte"}, got, td_m[sel]);
    td_pend_m[sel] = 1'b0;
    check({tag, ".r_din_idle"}, r_din, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [15:0] v;
    int nb, op, ch;

    // reset
    reset_n = 1'b0; dsr_en = 1'b1; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0;
    ti_a = 16'h0000; ti_d_in = 8'h00;
    r_clk = 1'b0; r_le = 1'b0; r_rt = 1'b0; r_sel = 1'b0; r_dout = 1'b0;
    model_reset();
    tick(3);
    check_flags("reset");
    check("reset.r_din", r_din, 1'b0);
    check("reset.oe", ti_d_oe, 1'b0);
    check("reset.dout", ti_d_out, 8'h00);
    reset_n = 1'b1;
    tick(3);

    // TI write then RPi load of channel 0
    ti_write(0, 8'hA5);
    check_flags("tiwr");
    ti_read_check("status1", N_CHAN);
    recv_check("load0", 0);
    check_flags("load0");

    // RPi commit to channel 1, TI reads it back
    rpi_send(1, 16'h003C, 8);
    check_flags("commit1");
    ti_read_check("rd1", 1);
    check_flags("rd1");

    // short frame: nothing committed, sticky error until STATUS read
    rpi_send(0, 16'h0015, 5);
    check_flags("short");
    ti_read_check("status_err", N_CHAN);
    ti_read_check("status_clr", N_CHAN);
    ti_read_check("rd0_old", 0);

    // disabled block: no write effect, no bus drive
    dsr_en = 1'b0;
    ti_write(0, 8'h5A);
    ti_read_check("dis_rd0", 0);
    check_flags("dis");
    dsr_en = 1'b1;
    tick(2);
    recv_check("dis_td0", 0);

    // TI write to channel 1 in the same cycle as the RPi load of channel 1
    ti_write(1, 8'h11);
    ti_a = td_adr[1]; ti_d_in = 8'h22; ti_memen = 1'b0; ti_we = 1'b0;
    r_rt = 1'b1; r_sel = 1'b1; r_le = 1'b1;
    tick(6);
    ti_we = 1'b1; ti_memen = 1'b1; r_le = 1'b0;
    tick(6);
    rpi_shift_out(b);
    check("race.byte", b, 8'h11);
    td_m[1] = 8'h22;
    td_pend_m[1] = 1'b1;
    check_flags("race");
    recv_check("race_new", 1);
    check_flags("race_new");

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      ch = $urandom_range(0, N_CHAN - 1);
      case (op)
        0: ti_write(ch, 8'($urandom_range(0, 255)));
        1: recv_check("rnd_recv", ch);
        2: begin
          nb = ($urandom_range(0, 2) != 0) ? 8 : $urandom_range(1, 10);
          v = 16'($urandom_range(0, 1023));
          rpi_send(ch, v, nb);
        end
        default: ti_read_check("rnd_read", $urandom_range(0, N_CHAN));
      endcase
      check_flags("rnd");
      if (op != 3) ti_read_check("rnd_status", N_CHAN);
    end

    // reset in the middle of a receive frame
    ti_write(0, 8'h77);
    r_rt = 1'b0; r_sel = 1'b0;
    for (int i = 0; i < 4; i++) rpi_bit(1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    tick(1);
    model_reset();
    check_flags("midrst");
    check("midrst.r_din", r_din, 1'b0);
    check("midrst.oe", ti_d_oe, 1'b0);
    reset_n = 1'b1;
    tick(2);
    b = 8'($urandom_range(0, 255));
    rpi_send(0, {8'h00, b}, 8);
    check_flags("postrst_commit");
    ti_read_check("postrst_rd0", 0);
    check_flags("postrst_read");
    recv_check("postrst_td0", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
